// File: rtl/pong_snd_pkg.sv
// Shared constants, FSM state type and priority helper for the pong sound arbiter.
package pong_snd_pkg;

  localparam int unsigned N_SRC     = 3;
  localparam int unsigned SRC_HIT   = 0;
  localparam int unsigned SRC_WALL  = 1;
  localparam int unsigned SRC_SCORE = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  // One-hot highest-priority member of a request set: score > hit > wall.
  function automatic logic [N_SRC-1:0] prio_pick(input logic [N_SRC-1:0] set);
    logic [N_SRC-1:0] pick;
    pick = '0;
    if (set[SRC_SCORE])     pick[SRC_SCORE] = 1'b1;
    else if (set[SRC_HIT])  pick[SRC_HIT]   = 1'b1;
    else if (set[SRC_WALL]) pick[SRC_WALL]  = 1'b1;
    return pick;
  endfunction

endpackage

// File: rtl/pong_sound_arbiter_timer.sv
// Loadable down-counter that saturates at zero; tc flags the terminal count.
module pong_snd_timer #(
  parameter int unsigned CNT_W = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/pong_sound_arbiter.sv
// Fixed-priority arbiter gating one of three tones onto the cabinet sound output.
module pong_sound_arbiter
  import pong_snd_pkg::*;
#(
  parameter int unsigned CNT_W     = 21,
  parameter int unsigned HIT_LEN   = 115000,
  parameter int unsigned WALL_LEN  = 115000,
  parameter int unsigned SCORE_LEN = 1718000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             req_hit,
  input  logic             req_wall,
  input  logic             req_score,
  input  logic             tone_hit,
  input  logic             tone_wall,
  input  logic             tone_score,
  output logic [N_SRC-1:0] grant,
  output logic             busy,
  output logic             snd
);

  if ((HIT_LEN == 0) || (WALL_LEN == 0) || (SCORE_LEN == 0)) begin : g_len_zero
    $error("pong_sound_arbiter: tone lengths must be non-zero");
  end
  if ((longint'(HIT_LEN) > (longint'(1) << CNT_W)) ||
      (longint'(WALL_LEN) > (longint'(1) << CNT_W)) ||
      (longint'(SCORE_LEN) > (longint'(1) << CNT_W))) begin : g_len_wide
    $error("pong_sound_arbiter: tone length does not fit the counter");
  end

  localparam logic [CNT_W-1:0] HIT_M1   = CNT_W'(HIT_LEN - 1);
  localparam logic [CNT_W-1:0] WALL_M1  = CNT_W'(WALL_LEN - 1);
  localparam logic [CNT_W-1:0] SCORE_M1 = CNT_W'(SCORE_LEN - 1);

  function automatic logic [CNT_W-1:0] len_m1(input logic [N_SRC-1:0] g);
    logic [CNT_W-1:0] v;
    v = '0;
    if (g[SRC_SCORE])     v = SCORE_M1;
    else if (g[SRC_HIT])  v = HIT_M1;
    else if (g[SRC_WALL]) v = WALL_M1;
    return v;
  endfunction

  state_e           state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] arb;
  logic [N_SRC-1:0] others;
  logic [N_SRC-1:0] top;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             dec;
  logic             tc;

  always_comb begin
    req = '0;
    req[SRC_HIT]   = req_hit;
    req[SRC_WALL]  = req_wall;
    req[SRC_SCORE] = req_score;
  end

  assign arb    = pend_q | req;
  assign others = arb & ~grant_q;
  assign top    = prio_pick(others);

  // Next-state: disable beats everything, then preempt > retrigger > terminal handoff > count.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    pend_d   = pend_q;
    load     = 1'b0;
    load_val = '0;
    dec      = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      grant_d = '0;
      pend_d  = '0;
      load    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb != '0) begin
            grant_d  = prio_pick(arb);
            load     = 1'b1;
            load_val = len_m1(grant_d);
            pend_d   = arb & ~grant_d;
            state_d  = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if ((others != '0) && (prio_pick(others | grant_q) != grant_q)) begin
            grant_d  = top;
            load     = 1'b1;
            load_val = len_m1(top);
            pend_d   = others & ~top;
          end else if (((req & grant_q) != '0) && !tc) begin
            load     = 1'b1;
            load_val = len_m1(grant_q);
            pend_d   = others;
          end else if (tc) begin
            if (others != '0) begin
              grant_d  = top;
              load     = 1'b1;
              load_val = len_m1(top);
              pend_d   = others & ~top;
            end else begin
              grant_d = '0;
              pend_d  = '0;
              state_d = ST_IDLE;
            end
          end else begin
            dec    = 1'b1;
            pend_d = others;
          end
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = '0;
          pend_d  = '0;
        end
      endcase
    end
    busy_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
    end
  end

  pong_snd_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .en       (dec),
    .tc       (tc)
  );

  assign grant = grant_q;
  assign busy  = busy_q;
  assign snd   = (grant_q[SRC_HIT]   & tone_hit)  |
                 (grant_q[SRC_WALL]  & tone_wall) |
                 (grant_q[SRC_SCORE] & tone_score);

endmodule

// File: tb/tb_pong_sound_arbiter.sv
// Scoreboard bench: a source/remaining-cycles model predicts grant each edge; a monitor checks it.
module tb_pong_sound_arbiter;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned HIT_LEN   = 4;
  localparam int unsigned WALL_LEN  = 3;
  localparam int unsigned SCORE_LEN = 8;

  logic       clk;
  logic       reset;
  logic       en;
  logic       req_hit, req_wall, req_score;
  logic       tone_hit, tone_wall, tone_score;
  logic [2:0] grant;
  logic       busy;
  logic       snd;

  pong_sound_arbiter #(
    .CNT_W     (CNT_W),
    .HIT_LEN   (HIT_LEN),
    .WALL_LEN  (WALL_LEN),
    .SCORE_LEN (SCORE_LEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .req_hit    (req_hit),
    .req_wall   (req_wall),
    .req_score  (req_score),
    .tone_hit   (tone_hit),
    .tone_wall  (tone_wall),
    .tone_score (tone_score),
    .grant      (grant),
    .busy       (busy),
    .snd        (snd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] exp_q[$];

  // Model: which source plays (0 hit, 1 wall, 2 score, -1 none), how many grant cycles remain,
  // and which sources are waiting.
  int cur = -1;
  int rem = 0;
  bit pend [3];

  function automatic int rank(input int s);
    return (s == 2) ? 2 : ((s == 0) ? 1 : 0);
  endfunction

  function automatic int len_of(input int s);
    return (s == 0) ? HIT_LEN : ((s == 1) ? WALL_LEN : SCORE_LEN);
  endfunction

  function automatic int best(input bit set [3]);
    int b;
    b = -1;
    for (int s = 0; s < 3; s++)
      if (set[s] && (b < 0 || rank(s) > rank(b))) b = s;
    return b;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit fh, input bit fw, input bit fs);
    bit set [3];
    bit oth [3];
    int b;
    if (r || !e) begin
      cur = -1; rem = 0;
      for (int s = 0; s < 3; s++) pend[s] = 1'b0;
      return;
    end
    set[0] = pend[0] | fh; set[1] = pend[1] | fw; set[2] = pend[2] | fs;
    for (int s = 0; s < 3; s++) oth[s] = set[s] && (s != cur);
    b = best(oth);
    if (cur < 0) begin
      if (b >= 0) begin
        cur = b; rem = len_of(b); oth[b] = 1'b0;
      end
    end else if (b >= 0 && rank(b) > rank(cur)) begin
      cur = b; rem = len_of(b); oth[b] = 1'b0;
    end else if (set[cur] && !pend[cur] && rem > 1) begin
      rem = len_of(cur);
    end else if (rem == 1) begin
      if (b >= 0) begin
        cur = b; rem = len_of(b); oth[b] = 1'b0;
      end else begin
        cur = -1; rem = 0;
      end
    end else begin
      rem = rem - 1;
    end
    for (int s = 0; s < 3; s++) pend[s] = oth[s];
  endtask

  // Drive one cycle of inputs, advance the model, and queue the grant expected after the edge.
  task automatic step(input bit r, input bit e, input bit h, input bit w, input bit s);
    logic [2:0] g;
    @(negedge clk);
    reset = r; en = e; req_hit = h; req_wall = w; req_score = s;
    tone_hit = 1'($urandom); tone_wall = 1'($urandom); tone_score = 1'($urandom);
    model_step(r, e, h, w, s);
    g = '0;
    if (cur >= 0) g[cur] = 1'b1;
    exp_q.push_back(g);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
  endtask

  initial begin : monitor
    logic [2:0] eg;
    logic       es;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        eg = exp_q.pop_front();
        es = (eg[0] & tone_hit) | (eg[1] & tone_wall) | (eg[2] & tone_score);
        check("grant", grant, eg);
        check("busy", {2'b00, busy}, {2'b00, |eg});
        check("snd", {2'b00, snd}, {2'b00, es});
      end
    end
  end

  initial begin : stim
    reset = 1'b1; en = 1'b1;
    req_hit = 1'b0; req_wall = 1'b0; req_score = 1'b0;
    tone_hit = 1'b0; tone_wall = 1'b0; tone_score = 1'b0;
    step(1'b1, 1'b1, 0, 0, 0);
    step(1'b1, 1'b1, 0, 0, 0);
    idle(2);
    // reset during a score tone, then a fresh hit
    step(0, 1, 0, 0, 1);
    idle(2);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    idle(2);
    step(0, 1, 1, 0, 0);
    idle(6);
    // single hit
    step(0, 1, 1, 0, 0);
    idle(6);
    // simultaneous hit + wall
    step(0, 1, 1, 1, 0);
    idle(9);
    // wall preempted by score
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1);
    idle(10);
    // hit retrigger
    step(0, 1, 1, 0, 0);
    idle(1);
    step(0, 1, 1, 0, 0);
    idle(8);
    // enable low ignores requests; dropping en mid-score clears pending
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    idle(12);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) != 0),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 11) == 0));
    end
    idle(12);
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
